// File: rtl/soc_or1k_wb_loader.sv
// Wishbone classic write initiator: packs a byte stream big-endian into 32-bit words,
// writes them to memory one cycle per word and holds the OR1K core in reset until done.
module soc_or1k_wb_loader #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          load_start_i,
  input  logic [AW-1:0] load_base_i,
  input  logic [31:0]   load_len_i,
  input  logic          load_valid_i,
  input  logic [7:0]    load_data_i,
  output logic          load_ready_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [31:0]   load_count_o,
  output logic          cpu_rst_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_we_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic [2:0]    wbm_cti_o,
  output logic [1:0]    wbm_bte_o,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic [31:0]   wbm_dat_i
);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, DONE, ERROR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] adr_q;
  logic [31:0]   word_q;
  logic [31:0]   rem_q;
  logic [31:0]   cnt_q;
  logic [3:0]    sel_q;
  logic [1:0]    idx_q;
  logic [7:0]    tmo_q;
  logic          err_q;
  logic          cpu_rst_q;

  logic          last_byte;
  logic          tmo_hit;
  logic [2:0]    pop;
  logic [31:0]   rem_after;
  logic          unused_in;

  function automatic logic [2:0] popcount4(input logic [3:0] s);
    return {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
  endfunction

  // rem_q counts bytes not yet acknowledged, so bytes buffered in this word are subtracted here
  assign last_byte = (rem_q == ({30'd0, idx_q} + 32'd1));
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign pop       = popcount4(sel_q);
  assign rem_after = rem_q - {29'd0, pop};
  assign unused_in = ^{wbm_dat_i, load_base_i[1:0]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    wbm_cyc_o    = 1'b0;
    wbm_stb_o    = 1'b0;
    wbm_we_o     = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (load_start_i) state_nxt = (load_len_i == 32'd0) ? DONE : FILL;
      end
      FILL: begin
        load_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (load_valid_i && (idx_q == 2'd3 || last_byte)) state_nxt = WRITE;
      end
      WRITE: begin
        busy_o    = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        if (wbm_err_i)      state_nxt = ERROR;
        else if (wbm_ack_i) state_nxt = (rem_after == 32'd0) ? DONE : FILL;
        else if (tmo_hit)   state_nxt = ERROR;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q     <= '0;
      word_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      tmo_q <= (state == WRITE) ? tmo_q + 8'd1 : 8'd0;
      case (state)
        IDLE, ERROR: begin
          if (load_start_i) begin
            adr_q     <= {load_base_i[AW-1:2], 2'b00};
            rem_q     <= load_len_i;
            cnt_q     <= '0;
            word_q    <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
          end
        end
        FILL: begin
          // lane 3-idx equals ~idx for a 2-bit index: first byte lands in [31:24]
          if (load_valid_i) begin
            word_q[{~idx_q, 3'b000} +: 8] <= load_data_i;
            sel_q[~idx_q]                 <= 1'b1;
            idx_q                         <= idx_q + 2'd1;
          end
        end
        WRITE: begin
          if (wbm_err_i) begin
            err_q <= 1'b1;
          end else if (wbm_ack_i) begin
            adr_q  <= adr_q + AW'(4);
            cnt_q  <= cnt_q + {29'd0, pop};
            rem_q  <= rem_after;
            word_q <= '0;
            sel_q  <= '0;
            idx_q  <= '0;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        DONE: cpu_rst_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign err_o        = err_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign load_count_o = cnt_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = word_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_cti_o    = 3'b000;
  assign wbm_bte_o    = 2'b00;

endmodule

// File: tb/tb_soc_or1k_wb_loader.sv
// Directed bench for soc_or1k_wb_loader: table of load jobs with hand-computed bus
// writes, plus sequences for bus error, timeout and reset in the middle of a write.
module tb_soc_or1k_wb_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic [31:0] len;
  logic        valid;
  logic [7:0]  data;
  logic        ready, busy, done, err, cpu_rst;
  logic [31:0] cnt;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, berr;
  logic [31:0] rdat = 32'h0;

  always #5 clk = ~clk;

  soc_or1k_wb_loader #(.AW(32), .TIMEOUT(255)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .load_start_i (start),
    .load_base_i  (base),
    .load_len_i   (len),
    .load_valid_i (valid),
    .load_data_i  (data),
    .load_ready_o (ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .load_count_o (cnt),
    .cpu_rst_o    (cpu_rst),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat),
    .wbm_sel_o    (sel),
    .wbm_we_o     (we),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_cti_o    (cti),
    .wbm_bte_o    (bte),
    .wbm_ack_i    (ack),
    .wbm_err_i    (berr),
    .wbm_dat_i    (rdat)
  );

  typedef struct {
    logic [31:0] base;
    logic [31:0] len;
    int          gap;
    int          ack_wait;
    int          poke;
    int          nwr;
    logic [31:0] adr0;
    logic [31:0] dat0;
    logic [3:0]  sel0;
    logic [31:0] adr1;
    logic [31:0] dat1;
    logic [3:0]  sel1;
  } job_t;

  job_t jobs [7];

  int n_chk = 0;
  int n_fail = 0;

  int          n_wr, done_cnt, ready_viol, stab_viol, cyc_cycles, timed_out;
  int          cpu_rst_at_done, cpu_rst_after, done_after, err_after_start;
  logic [31:0] cnt_end;
  logic [31:0] wr_adr [8];
  logic [31:0] wr_dat [8];
  logic [3:0]  wr_sel [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Streams bytes 1..l, acts as the memory slave and records every acknowledged write.
  // err_at / rst_at select the write index that gets a bus error or a reset instead of ack.
  task automatic run_job(input logic [31:0] b, input logic [31:0] l, input int gap,
                         input int ack_wait, input int poke, input int err_at, input int rst_at);
    int          sent, wait_cnt, wr_idx;
    logic [31:0] ref_adr, ref_dat;
    logic [3:0]  ref_sel;
    bit          fin;
    n_wr = 0; done_cnt = 0; ready_viol = 0; stab_viol = 0; cyc_cycles = 0; timed_out = 1;
    cpu_rst_at_done = 0; cpu_rst_after = 0; done_after = 0; cnt_end = '0;
    sent = 0; wait_cnt = 0; wr_idx = 0; fin = 0;
    ref_adr = '0; ref_dat = '0; ref_sel = '0;
    @(negedge clk);
    start = 1'b1; base = b; len = l;
    @(negedge clk);
    start = 1'b0;
    err_after_start = int'(err);
    for (int c = 0; c < 800 && !fin; c++) begin
      if (done) begin
        done_cnt++;
        cpu_rst_at_done = int'(cpu_rst);
        valid = 1'b0; ack = 1'b0; berr = 1'b0;
        @(negedge clk);
        done_after    = int'(done);
        cpu_rst_after = int'(cpu_rst);
        cnt_end       = cnt;
        timed_out = 0; fin = 1;
      end else if (err) begin
        valid = 1'b0; ack = 1'b0; berr = 1'b0;
        timed_out = 0; fin = 1;
      end else begin
        start = (poke != 0 && c == 3);
        if (poke != 0 && c == 3) begin
          base = 32'hDEAD0000; len = 32'd99;
        end
        if (ready && sent < int'(l) && (gap == 0 || c % 2 == 1)) begin
          valid = 1'b1; data = 8'(sent + 1); sent++;
        end else begin
          valid = 1'b0; data = 8'hEE;
        end
        ack = 1'b0; berr = 1'b0;
        if (cyc) begin
          cyc_cycles++;
          if (ready || !busy || !stb || !we) ready_viol++;
          if (wait_cnt == 0) begin
            ref_adr = adr; ref_dat = dat; ref_sel = sel;
          end else if (adr !== ref_adr || dat !== ref_dat || sel !== ref_sel) begin
            stab_viol++;
          end
          if (wr_idx == rst_at) begin
            rst = 1'b1; valid = 1'b0;
            timed_out = 0; fin = 1;
          end else if (wait_cnt >= ack_wait) begin
            ack = 1'b1;
            if (wr_idx == err_at) begin
              berr = 1'b1;
            end else begin
              if (n_wr < 8) begin
                wr_adr[n_wr] = adr; wr_dat[n_wr] = dat; wr_sel[n_wr] = sel;
              end
              n_wr++;
            end
            wr_idx++;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
        if (!fin) @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; valid = 1'b0; data = '0;
    ack = 1'b0; berr = 1'b0;

    jobs[0] = '{base:32'h100, len:8, gap:0, ack_wait:0, poke:0, nwr:2,
                adr0:32'h100, dat0:32'h01020304, sel0:4'hF,
                adr1:32'h104, dat1:32'h05060708, sel1:4'hF};
    jobs[1] = '{base:32'h203, len:6, gap:0, ack_wait:0, poke:0, nwr:2,
                adr0:32'h200, dat0:32'h01020304, sel0:4'hF,
                adr1:32'h204, dat1:32'h05060000, sel1:4'hC};
    jobs[2] = '{base:32'h300, len:8, gap:1, ack_wait:10, poke:1, nwr:2,
                adr0:32'h300, dat0:32'h01020304, sel0:4'hF,
                adr1:32'h304, dat1:32'h05060708, sel1:4'hF};
    jobs[3] = '{base:32'h1000, len:1, gap:0, ack_wait:0, poke:0, nwr:1,
                adr0:32'h1000, dat0:32'h01000000, sel0:4'h8,
                adr1:32'h0, dat1:32'h0, sel1:4'h0};
    jobs[4] = '{base:32'h2001, len:3, gap:0, ack_wait:2, poke:0, nwr:1,
                adr0:32'h2000, dat0:32'h01020300, sel0:4'hE,
                adr1:32'h0, dat1:32'h0, sel1:4'h0};
    jobs[5] = '{base:32'hFFFFFFFC, len:5, gap:1, ack_wait:1, poke:0, nwr:2,
                adr0:32'hFFFFFFFC, dat0:32'h01020304, sel0:4'hF,
                adr1:32'h0, dat1:32'h05000000, sel1:4'h8};
    jobs[6] = '{base:32'h40, len:0, gap:0, ack_wait:0, poke:0, nwr:0,
                adr0:32'h0, dat0:32'h0, sel0:4'h0,
                adr1:32'h0, dat1:32'h0, sel1:4'h0};

    repeat (3) @(negedge clk);
    chk("reset cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reset cyc/stb/we", {29'd0, cyc, stb, we}, 32'd0);
    chk("reset busy/done/err/ready", {28'd0, busy, done, err, ready}, 32'd0);
    chk("reset load_count", cnt, 32'd0);
    chk("reset adr", adr, 32'd0);
    chk("reset dat", dat, 32'd0);
    chk("reset sel/cti/bte", {23'd0, sel, cti, bte}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_job(jobs[i].base, jobs[i].len, jobs[i].gap, jobs[i].ack_wait, jobs[i].poke, -1, -1);
      chk($sformatf("job%0d budget", i), 32'(timed_out), 32'd0);
      chk($sformatf("job%0d err cleared", i), 32'(err_after_start), 32'd0);
      chk($sformatf("job%0d write count", i), 32'(n_wr), 32'(jobs[i].nwr));
      if (jobs[i].nwr > 0) begin
        chk($sformatf("job%0d wr0 adr", i), wr_adr[0], jobs[i].adr0);
        chk($sformatf("job%0d wr0 dat", i), wr_dat[0], jobs[i].dat0);
        chk($sformatf("job%0d wr0 sel", i), {28'd0, wr_sel[0]}, {28'd0, jobs[i].sel0});
      end
      if (jobs[i].nwr > 1) begin
        chk($sformatf("job%0d wr1 adr", i), wr_adr[1], jobs[i].adr1);
        chk($sformatf("job%0d wr1 dat", i), wr_dat[1], jobs[i].dat1);
        chk($sformatf("job%0d wr1 sel", i), {28'd0, wr_sel[1]}, {28'd0, jobs[i].sel1});
      end
      chk($sformatf("job%0d done pulses", i), 32'(done_cnt), 32'd1);
      chk($sformatf("job%0d done width", i), 32'(done_after), 32'd0);
      chk($sformatf("job%0d cpu_rst at done", i), 32'(cpu_rst_at_done), 32'd1);
      chk($sformatf("job%0d cpu_rst after", i), 32'(cpu_rst_after), 32'd0);
      chk($sformatf("job%0d load_count", i), cnt_end, jobs[i].len);
      chk($sformatf("job%0d ready/strobe in write", i), 32'(ready_viol), 32'd0);
      chk($sformatf("job%0d write stable", i), 32'(stab_viol), 32'd0);
    end

    // bus error on the second word, presented together with ack
    run_job(32'h500, 32'd8, 0, 1, 0, 1, -1);
    chk("buserr budget", 32'(timed_out), 32'd0);
    chk("buserr err_o", 32'(err), 32'd1);
    chk("buserr cpu_rst", 32'(cpu_rst), 32'd1);
    chk("buserr cyc/stb", {30'd0, cyc, stb}, 32'd0);
    chk("buserr busy", 32'(busy), 32'd0);
    chk("buserr load_count", cnt, 32'd4);
    chk("buserr first write", wr_dat[0], 32'h01020304);
    @(negedge clk);
    chk("buserr err sticky", 32'(err), 32'd1);
    run_job(32'h600, 32'd4, 0, 0, 0, -1, -1);
    chk("restart err cleared", 32'(err_after_start), 32'd0);
    chk("restart done", 32'(done_cnt), 32'd1);
    chk("restart load_count", cnt_end, 32'd4);
    chk("restart adr", wr_adr[0], 32'h600);

    // slave never answers
    run_job(32'h700, 32'd4, 0, 1000000, 0, -1, -1);
    chk("timeout budget", 32'(timed_out), 32'd0);
    chk("timeout cyc cycles", 32'(cyc_cycles), 32'd255);
    chk("timeout err_o", 32'(err), 32'd1);
    chk("timeout cyc", 32'(cyc), 32'd0);
    chk("timeout cpu_rst", 32'(cpu_rst), 32'd1);
    chk("timeout load_count", cnt, 32'd0);

    // reset while the second word is on the bus
    run_job(32'h800, 32'd8, 0, 2, 0, -1, 1);
    chk("midrst budget", 32'(timed_out), 32'd0);
    chk("midrst pre count", cnt, 32'd4);
    @(negedge clk);
    chk("midrst cyc/stb", {30'd0, cyc, stb}, 32'd0);
    chk("midrst cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst load_count", cnt, 32'd0);
    chk("midrst sel/dat", {sel, dat[27:0]}, 32'd0);
    rst = 1'b0;
    run_job(jobs[0].base, jobs[0].len, 0, 0, 0, -1, -1);
    chk("recover wr count", 32'(n_wr), 32'd2);
    chk("recover wr0 dat", wr_dat[0], 32'h01020304);
    chk("recover wr1 adr", wr_adr[1], 32'h104);
    chk("recover load_count", cnt_end, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_or1k_wb_loader.md
Name: soc_or1k_wb_loader

Overview:
- Synthesizable Wishbone classic initiator that writes a program image into the SoC memory slave over the bus. It replaces simulation-only backdoor ELF preloading.
- Accepts a byte stream (e.g. from a debug/UART bridge) and packs it big-endian into 32-bit words. Each word is issued as a single write cycle.
- Holds the OR1K core in reset while loading and releases it on successful completion.

Parameters:
- AW, 32, Wishbone address width.
- TIMEOUT, 255, max cycles a write may wait for ack/err before aborting (8-bit counter, 1..255).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- load_start_i  in  1  start pulse; samples load_base_i/load_len_i
- load_base_i  in  AW  byte base address; bits [1:0] forced to 0
- load_len_i  in  32  image length in bytes
- load_valid_i  in  1  stream byte valid
- load_data_i  in  8  stream byte
- load_ready_o  out  1  loader accepts byte this cycle
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse on successful completion
- err_o  out  1  sticky bus error/timeout flag
- load_count_o  out  32  bytes written and acknowledged
- cpu_rst_o  out  1  core reset request
- wbm_adr_o  out  AW  address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  cycle type, constant 3'b000
- wbm_bte_o  out  2  burst type, constant 2'b00
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error
- wbm_dat_i  in  32  read data, unused

Behaviour:
- Interface decision: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values:
  - All outputs 0, except cpu_rst_o=1.
  - State IDLE; word buffer, counters and sel mask cleared.
- States: IDLE, FILL, WRITE, DONE, ERROR.
- IDLE:
  - On load_start_i, latch base and len, clear load_count_o and err_o, set cpu_rst_o=1.
  - len==0 → DONE; otherwise → FILL.
- FILL:
  - load_ready_o=1 (decoded from state).
  - Each byte accepted on load_valid_i&&load_ready_o goes to lane 3-idx: first byte → [31:24], fourth → [7:0]. The matching sel bit is set.
  - Transition to WRITE on the cycle the 4th byte is accepted, or the last byte of the image (remaining==1). load_ready_o is 0 from the next cycle.
- WRITE:
  - cyc=stb=we=1; adr=current word address; dat=packed word; sel=accumulated mask. Unused lanes carry 0.
  - Outputs are stable until ack/err.
  - ack: adr+=4 (wraps modulo 2^AW); load_count_o and remaining updated by popcount(sel); buffer and sel cleared; cyc/stb drop the next cycle. remaining==0 → DONE, else → FILL.
  - err (ack and err together: err wins) → ERROR.
  - Timeout counter clears on entering WRITE and increments each cycle without ack/err. On reaching TIMEOUT → ERROR, dropping cyc/stb.
- DONE:
  - done_o=1 for exactly one cycle, cpu_rst_o←0, → IDLE.
- ERROR:
  - err_o=1 (sticky), cpu_rst_o stays 1, cyc/stb=0.
  - load_start_i restarts as from IDLE.
- busy_o=1 in FILL and WRITE.
- load_start_i during FILL/WRITE is ignored.
- Partial last word, bytes 1/2/3: sel=4'b1000/4'b1100/4'b1110.
- Reset asserted mid-transfer: cyc/stb=0 and all outputs at reset values from the next edge. The partial word is discarded.

Test Plan:
- Reset, load_base=0x100, load_len=8, bytes 0x01..0x08 streamed with immediate ack → writes 0x01020304@0x100 and 0x05060708@0x104, both sel=4'hF. Then done_o pulse, cpu_rst_o 1→0, load_count_o=8.
- load_len=6, base 0x203 → first write @0x200 sel=F; second 0x05060000 @0x204 sel=4'b1100; load_count_o=6.
- Slave responds with wbm_err_i on the 2nd write → err_o=1, cpu_rst_o=1, cyc=0, load_count_o=4. A new load_start_i clears err_o.
- Slave never acks, TIMEOUT=255 → cyc drops exactly 255 cycles after WRITE entry and err_o=1.
- Gapped load_valid_i plus 10 wait cycles before ack → ready low while WRITE; no bytes lost or duplicated. load_start_i mid-load is ignored.
- wb_rst_i pulsed during WRITE → next cycle cyc/stb=0, cpu_rst_o=1, busy_o=0, load_count_o=0.
